// File: rtl/bin_to_bcd_disp.sv
// bin_to_bcd_disp
//   Converts a 27-bit unsigned binary value into 8 packed BCD digits for a
//   7-segment display, using a serial double-dabble engine (one step per
//   clock, 27 steps). Values above 99_999_999 saturate to 9999_9999 and
//   raise ovf. Latency from the accepting edge to the done pulse is a fixed
//   28 cycles.
//
// Ports
//   clk    in   1   system clock, rising edge
//   rst    in   1   synchronous active-high reset
//   bin    in  27   value to convert, sampled on the accepting edge only
//   start  in   1   conversion request, accepted when ready=1
//   ready  out  1   idle and able to accept start
//   done   out  1   one-cycle pulse: bcd/blank/ovf just updated
//   bcd    out 32   digit 0 in [3:0] .. digit 7 in [31:28]
//   blank  out  8   bit i set when digit i is a leading zero (bit 0 always 0)
//   ovf    out  1   last accepted bin exceeded 99_999_999
module bin_to_bcd_disp (
  input  logic        clk,
  input  logic        rst,
  input  logic [26:0] bin,
  input  logic        start,
  output logic        ready,
  output logic        done,
  output logic [31:0] bcd,
  output logic [7:0]  blank,
  output logic        ovf
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [26:0] MAX_DEC  = 27'd99_999_999;
  localparam logic [4:0]  LAST_IDX = 5'd26;  // index of the 27th step

  logic [1:0]  r_state;
  logic [26:0] r_shreg;
  logic [31:0] r_work;
  logic [4:0]  r_cnt;
  logic        r_ovf_pend;
  logic        r_done;
  logic [31:0] r_bcd;
  logic [7:0]  r_blank;
  logic        r_ovf;

  logic [31:0] w_adj;
  logic [31:0] w_new;
  logic [7:0]  w_blank;
  logic        w_accept;

  assign ready    = (r_state == S_IDLE) && !rst;
  assign w_accept = ready && start;

  // Double-dabble correction: any nibble >= 5 gets +3 so that the following
  // left shift carries correctly into the next decimal digit.
  always_comb begin
    w_adj = '0;
    for (int i = 0; i < 8; i++) begin
      if (r_work[4*i +: 4] >= 4'd5)
        w_adj[4*i +: 4] = r_work[4*i +: 4] + 4'd3;
      else
        w_adj[4*i +: 4] = r_work[4*i +: 4];
    end
  end

  // Value to publish at DONE; saturation also makes every blank bit 0.
  assign w_new = r_ovf_pend ? 32'h9999_9999 : r_work;

  // Leading-zero mask: digit i is blank when it and every digit above it
  // are zero. Digit 0 is always shown so a zero value reads "0".
  always_comb begin
    w_blank    = '0;
    w_blank[7] = (w_new[31:28] == 4'd0);
    for (int i = 6; i >= 1; i--)
      w_blank[i] = w_blank[i+1] && (w_new[4*i +: 4] == 4'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_shreg    <= '0;
      r_work     <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      r_done     <= 1'b0;
      r_bcd      <= '0;
      r_blank    <= 8'hFE;
      r_ovf      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_shreg    <= bin;
            r_work     <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= (bin > MAX_DEC);
            r_state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // Shift {work, shreg} left by one after the nibble correction.
          r_work  <= {w_adj[30:0], r_shreg[26]};
          r_shreg <= {r_shreg[25:0], 1'b0};
          r_cnt   <= r_cnt + 5'd1;
          if (r_cnt == LAST_IDX)
            r_state <= S_DONE;
        end
        S_DONE: begin
          r_bcd   <= w_new;
          r_blank <= w_blank;
          r_ovf   <= r_ovf_pend;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign done  = r_done;
  assign bcd   = r_bcd;
  assign blank = r_blank;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_bin_to_bcd_disp.sv
module tb_bin_to_bcd_disp;

  logic        clk = 1'b0;
  logic        rst;
  logic [26:0] bin;
  logic        start;
  logic        ready;
  logic        done;
  logic [31:0] bcd;
  logic [7:0]  blank;
  logic        ovf;

  int checks   = 0;
  int failures = 0;

  bin_to_bcd_disp dut (
    .clk   (clk),
    .rst   (rst),
    .bin   (bin),
    .start (start),
    .ready (ready),
    .done  (done),
    .bcd   (bcd),
    .blank (blank),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  // Reference: decimal digits by division, leading zeros by magnitude.
  function automatic void model(input int unsigned v, output logic [31:0] b,
                                output logic [7:0] bl, output logic o);
    int unsigned p;
    b  = '0;
    bl = '0;
    o  = (v > 99_999_999);
    if (o) begin
      b = 32'h9999_9999;
    end else begin
      p = 1;
      for (int k = 0; k < 8; k++) begin
        b[4*k +: 4] = 4'((v / p) % 10);
        if (k >= 1) bl[k] = (v < p);
        p = p * 10;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic conv(input logic [26:0] v, input string tag);
    int n;
    bit got;
    logic [31:0] eb;
    logic [7:0]  ebl;
    logic        eo;
    model(32'(v), eb, ebl, eo);
    @(negedge clk);
    bin   = v;
    start = 1'b1;
    chk({tag, "_ready_before"}, 32'(ready), 32'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    bin   = 27'($urandom);  // must not disturb the conversion in flight
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (done) got = 1'b1;
    end
    chk({tag, "_latency"}, 32'(n), 32'd28);
    chk({tag, "_bcd"}, bcd, eb);
    chk({tag, "_blank"}, 32'(blank), 32'(ebl));
    chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
    chk({tag, "_ready_at_done"}, 32'(ready), 32'd1);
    @(posedge clk);
    #1;
    chk({tag, "_done_1cyc"}, 32'(done), 32'd0);
    chk({tag, "_bcd_hold"}, bcd, eb);
  endtask

  initial begin
    logic [26:0] q[$];
    int          cyc, last_acc, n_acc, n_done;
    bit          r;
    logic [31:0] eb;
    logic [7:0]  ebl;
    logic        eo;
    bit          saw_done;

    rst = 1'b1; start = 1'b0; bin = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bcd", bcd, 32'd0);
    chk("rst_blank", 32'(blank), 32'hFE);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_release_ready", 32'(ready), 32'd1);

    conv(27'd12_345_678, "d12345678");
    chk("d12345678_const", bcd, 32'h1234_5678);
    conv(27'd0, "d0");
    chk("d0_blank_const", 32'(blank), 32'hFE);
    conv(27'd42, "d42");
    chk("d42_const", bcd, 32'h0000_0042);
    conv(27'd99_999_999, "dmax");
    conv(27'd100_000_000, "dovf");
    chk("dovf_const", 32'(ovf), 32'd1);
    conv(27'h7FF_FFFF, "dallones");
    for (int i = 0; i < 6; i++) conv(27'($urandom), $sformatf("rnd%0d", i));
    for (int i = 0; i < 4; i++) conv(27'($urandom_range(0, 999)), $sformatf("rsm%0d", i));

    // start held high, bin changing every cycle
    cyc = 0; last_acc = -1; n_acc = 0; n_done = 0;
    for (int i = 0; i < 100 || (q.size() != 0 && i < 140); i++) begin
      @(negedge clk);
      bin   = 27'($urandom);
      start = (i < 100);
      r     = ready && start;
      @(posedge clk);
      cyc++;
      if (r) begin
        q.push_back(bin);
        if (last_acc >= 0) chk("hold_interval", 32'(cyc - last_acc), 32'd29);
        last_acc = cyc;
        n_acc++;
      end
      #1;
      if (done) begin
        n_done++;
        if (q.size() == 0) begin
          chk("hold_spurious_done", 32'd1, 32'd0);
        end else begin
          model(32'(q.pop_front()), eb, ebl, eo);
          chk("hold_latency", 32'(cyc - last_acc), 32'd28);
          chk("hold_bcd", bcd, eb);
          chk("hold_blank", 32'(blank), 32'(ebl));
          chk("hold_ovf", 32'(ovf), 32'(eo));
        end
      end
    end
    start = 1'b0;
    chk("hold_accepts", 32'(n_acc), 32'd4);
    chk("hold_done_count", 32'(n_done), 32'(n_acc));

    // reset in the middle of SHIFT
    @(negedge clk);
    bin = 27'd55_555_555; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_ready_in_rst", 32'(ready), 32'd0);
    @(posedge clk);
    #1;
    chk("abort_bcd", bcd, 32'd0);
    chk("abort_blank", 32'(blank), 32'hFE);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_ready_after", 32'(ready), 32'd1);
    saw_done = 1'b0;
    repeat (35) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    chk("abort_no_done", 32'(saw_done), 32'd0);
    chk("abort_bcd_stays", bcd, 32'd0);
    conv(27'd7, "after_abort");
    chk("after_abort_bcd_const", bcd, 32'h0000_0007);
    chk("after_abort_blank_const", 32'(blank), 32'hFE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
